// File: rtl/gpr_issue_scoreboard.sv
// gpr_issue_scoreboard: per-warp register pending-write scoreboard plus the
// elastic issue register that feeds the GPR read request. Instructions whose
// sources (RAW) or destination (WAW) are pending are held in the ibuf.
module gpr_issue_scoreboard #(
    parameter int NUM_WARPS = 4,
    parameter int NUM_REGS  = 32,
    parameter int TAGW      = 64,
    parameter int CNTW      = 32,
    localparam int NWB      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RB       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibuf_valid,
    output logic                 ibuf_ready,
    input  logic [NWB-1:0]       ibuf_wid,
    input  logic                 ibuf_wb,
    input  logic [RB-1:0]        ibuf_rd,
    input  logic [RB-1:0]        ibuf_rs1,
    input  logic [RB-1:0]        ibuf_rs2,
    input  logic [RB-1:0]        ibuf_rs3,
    input  logic [2:0]           ibuf_use_rs,
    input  logic [TAGW-1:0]      ibuf_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NWB-1:0]       out_wid,
    output logic [RB-1:0]        out_rs1,
    output logic [RB-1:0]        out_rs2,
    output logic [RB-1:0]        out_rs3,
    output logic [TAGW-1:0]      out_tag,
    input  logic                 wb_valid,
    input  logic [NWB-1:0]       wb_wid,
    input  logic [RB-1:0]        wb_rd,
    input  logic                 wb_eop,
    output logic [NUM_WARPS-1:0] pending_any,
    output logic [CNTW-1:0]      stall_cnt
);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] pend_nxt;
    logic [NUM_REGS-1:0]                pend_w;
    logic                               hazard;
    logic                               fire;
    logic                               set_en;
    logic                               clr_en;

    // Hazard check of the presented instruction against its warp's pending bits
    always_comb begin
        pend_w = pend[ibuf_wid];
        hazard = (ibuf_use_rs[0] & pend_w[ibuf_rs1])
               | (ibuf_use_rs[1] & pend_w[ibuf_rs2])
               | (ibuf_use_rs[2] & pend_w[ibuf_rs3])
               | (ibuf_wb        & pend_w[ibuf_rd]);
    end

    assign ibuf_ready = !hazard && (!out_valid || out_ready);
    assign fire       = ibuf_valid && ibuf_ready;
    assign set_en     = fire && ibuf_wb && (ibuf_rd != '0);
    assign clr_en     = wb_valid && wb_eop && (wb_rd != '0);

    // Next pending state: clear applied first so a same-entry set wins
    always_comb begin
        pend_nxt = pend;
        if (clr_en) pend_nxt[wb_wid][wb_rd] = 1'b0;
        if (set_en) pend_nxt[ibuf_wid][ibuf_rd] = 1'b1;
    end

    // Pending-bit storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pend <= '0;
        else        pend <= pend_nxt;
    end

    // Elastic issue register toward the GPR read stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_rs1   <= '0;
            out_rs2   <= '0;
            out_rs3   <= '0;
            out_tag   <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_wid   <= ibuf_wid;
            out_rs1   <= ibuf_rs1;
            out_rs2   <= ibuf_rs2;
            out_rs3   <= ibuf_rs3;
            out_tag   <= ibuf_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles a valid instruction is held by a hazard
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_cnt <= '0;
        else if (ibuf_valid && hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNTW'(1);
    end

    // Per-warp summary of outstanding writes
    always_comb begin
        pending_any = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) pending_any[w] = |pend[w];
    end

    // A final writeback beat must target a pending entry; the only exception is
    // the race where the same entry is being re-set by an issue in that cycle.
    clear_targets_pending: assert property (@(posedge clk) disable iff (!reset)
        (clr_en && !(set_en && (wb_wid == ibuf_wid) && (wb_rd == ibuf_rd)))
            |-> pend[wb_wid][wb_rd]);

endmodule
